grid_io_bank_cfg: RTL and testbench



---
 rtl/grid_io_bank_cfg.sv | 104 ++++++++++
 tb/tb_grid_io_bank_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_bank_cfg.sv
// NUM_IO-pad fabric-edge IO bank: serial ccff config chain, shadow (active) config, per-pad OE/out-reg/sync/invert.
// Latency: out_reg path 1 cycle, synchronised input SYNC_STAGES cycles; no backpressure, one chain bit per ccff_en cycle.
module grid_io_bank_cfg #(
    parameter int NUM_IO          = 8,
    parameter int CFG_BITS_PER_IO = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    output logic              ccff_tail,
    output logic              cfg_valid,
    output logic              cfg_done,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD
);
    localparam int TOTAL = NUM_IO * CFG_BITS_PER_IO;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

    localparam int F_OE      = 0;
    localparam int F_OUT_REG = 1;
    localparam int F_IN_REG  = 2;
    localparam int F_INV     = 3;

    logic [TOTAL-1:0]       sr;
    logic [TOTAL-1:0]       sr_next;
    logic [TOTAL-1:0]       active;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   load_complete;
    logic [NUM_IO-1:0]      out_q;
    logic [SYNC_STAGES-1:0] sync_q [NUM_IO];

    // A full counter wraps to 1 so the bit shifted after completion starts the next load.
    always_comb begin
        sr_next       = {sr[TOTAL-2:0], ccff_head};
        count_next    = (count == TOTAL_C) ? CW'(1) : count + CW'(1);
        load_complete = ccff_en && (count_next == TOTAL_C);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr        <= '0;
            count     <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= load_complete;
            if (ccff_en) begin
                sr    <= sr_next;
                count <= count_next;
            end
            if (load_complete) begin
                active    <= sr_next;
                cfg_valid <= 1'b1;
            end
        end
    end

    assign ccff_tail = sr[TOTAL-1];

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            out_q <= '0;
            for (int k = 0; k < NUM_IO; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            out_q <= io_outpad;
            for (int k = 0; k < NUM_IO; k++) begin
                sync_q[k][0] <= gfpga_pad_GPIO_PAD[k];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[k][s] <= sync_q[k][s-1];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_IO; k++) begin : g_pad
        logic oe;
        logic out_reg;
        logic in_reg;
        logic inv;
        logic drive_val;
        logic in_raw;

        assign oe      = active[k*CFG_BITS_PER_IO + F_OE];
        assign out_reg = active[k*CFG_BITS_PER_IO + F_OUT_REG];
        assign in_reg  = active[k*CFG_BITS_PER_IO + F_IN_REG];
        assign inv     = active[k*CFG_BITS_PER_IO + F_INV];

        assign drive_val             = out_reg ? out_q[k] : io_outpad[k];
        assign gfpga_pad_GPIO_PAD[k] = (cfg_valid && oe) ? drive_val : 1'bz;

        // The pad is read back even while driven, giving loopback when oe is set.
        assign in_raw      = in_reg ? sync_q[k][SYNC_STAGES-1] : gfpga_pad_GPIO_PAD[k];
        assign io_inpad[k] = cfg_valid & (in_raw ^ inv);
    end

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Randomised bench for grid_io_bank_cfg against a history-based reference model.
module tb_grid_io_bank_cfg;
    localparam int N     = 8;
    localparam int CB    = 4;
    localparam int SYNC  = 2;
    localparam int TOTAL = N * CB;

    logic         prog_clk;
    logic         pReset;
    logic         ccff_head;
    logic         ccff_en;
    logic         ccff_tail;
    logic         cfg_valid;
    logic         cfg_done;
    logic [N-1:0] io_outpad;
    logic [N-1:0] io_inpad;
    wire  [N-1:0] pad;

    logic [N-1:0] ext_en;
    logic [N-1:0] ext_val;

    for (genvar g = 0; g < N; g++) begin : g_ext
        assign pad[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    grid_io_bank_cfg #(
        .NUM_IO          (N),
        .CFG_BITS_PER_IO (CB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .prog_clk           (prog_clk),
        .pReset             (pReset),
        .ccff_head          (ccff_head),
        .ccff_en            (ccff_en),
        .ccff_tail          (ccff_tail),
        .cfg_valid          (cfg_valid),
        .cfg_done           (cfg_done),
        .io_outpad          (io_outpad),
        .io_inpad           (io_inpad),
        .gfpga_pad_GPIO_PAD (pad)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: every bit shifted since reset (most recent first).
    logic         hist [$];
    int           nshift;
    logic [TOTAL-1:0] act_m;
    logic         valid_m;
    logic         done_m;
    logic [N-1:0] outq_m;
    logic [N-1:0] sync_m [SYNC];
    logic         armed = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [TOTAL-1:0] chain_m();
        logic [TOTAL-1:0] v = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if (i < hist.size()) v[i] = hist[i];
        end
        return v;
    endfunction

    function automatic logic [N-1:0] drv_mask();
        logic [N-1:0] m;
        for (int k = 0; k < N; k++) m[k] = valid_m && act_m[k*CB + 0];
        return m;
    endfunction

    function automatic logic [N-1:0] exp_pad();
        logic [N-1:0] p;
        logic [N-1:0] m = drv_mask();
        for (int k = 0; k < N; k++) begin
            if (m[k]) p[k] = act_m[k*CB + 1] ? outq_m[k] : io_outpad[k];
            else      p[k] = ext_val[k];
        end
        return p;
    endfunction

    function automatic logic [N-1:0] exp_inpad();
        logic [N-1:0] p = exp_pad();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            logic raw;
            raw  = act_m[k*CB + 2] ? sync_m[SYNC-1][k] : p[k];
            r[k] = valid_m & (raw ^ act_m[k*CB + 3]);
        end
        return r;
    endfunction

    task automatic check_all();
        logic exp_tail;
        exp_tail = (hist.size() >= TOTAL) ? hist[TOTAL-1] : 1'b0;
        chk_eq("cfg_valid", 64'(cfg_valid), 64'(valid_m));
        chk_eq("cfg_done",  64'(cfg_done),  64'(done_m));
        chk_eq("ccff_tail", 64'(ccff_tail), 64'(exp_tail));
        chk_eq("pad",       64'(pad),       64'(exp_pad()));
        chk_eq("io_inpad",  64'(io_inpad),  64'(exp_inpad()));
    endtask

    task automatic model_edge();
        if (pReset) begin
            hist.delete();
            nshift  = 0;
            act_m   = '0;
            valid_m = 1'b0;
            done_m  = 1'b0;
            outq_m  = '0;
            for (int s = 0; s < SYNC; s++) sync_m[s] = '0;
            armed   = 1'b1;
        end else begin
            for (int s = SYNC-1; s > 0; s--) sync_m[s] = sync_m[s-1];
            sync_m[0] = exp_pad();
            outq_m    = io_outpad;
            done_m    = 1'b0;
            if (ccff_en) begin
                hist.push_front(ccff_head);
                if (hist.size() > TOTAL) void'(hist.pop_back());
                nshift++;
                if (nshift % TOTAL == 0) begin
                    act_m   = chain_m();
                    valid_m = 1'b1;
                    done_m  = 1'b1;
                end
            end
        end
    endtask

    // Called 1 time unit after a rising edge; drives, checks mid-cycle, then advances one edge.
    task automatic cycle(input logic rst, input logic en, input logic head);
        pReset    = rst;
        ccff_en   = en;
        ccff_head = head;
        io_outpad = N'($urandom);
        ext_val   = N'($urandom);
        ext_en    = ~drv_mask();
        #3;
        if (armed) check_all();
        @(posedge prog_clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'($urandom));
    endtask

    // Bit TOTAL-1 goes first so that cfg[i] ends up in chain position i.
    task automatic load_cfg(input logic [TOTAL-1:0] cfg, input int gap);
        for (int i = TOTAL-1; i >= 0; i--) begin
            cycle(1'b0, 1'b1, cfg[i]);
            if (i > 0) idle(gap);
        end
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'($urandom));
    endtask

    initial begin
        pReset    = 1'b1;
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
        io_outpad = '0;
        ext_en    = '1;
        ext_val   = '0;
        nshift    = 0;
        act_m     = '0;
        valid_m   = 1'b0;
        done_m    = 1'b0;
        outq_m    = '0;
        for (int s = 0; s < SYNC; s++) sync_m[s] = '0;
        @(posedge prog_clk);
        #1;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 1'($urandom));

        load_cfg(32'h0000_0001, 0);
        idle(8);

        load_cfg(32'h0000_00F0, 0);
        idle(12);

        load_cfg(32'h8000_0000, 3);
        idle(4);

        shift_rand(10);
        idle(10);
        shift_rand(22);
        idle(6);

        shift_rand(16);
        cycle(1'b1, 1'b1, 1'($urandom));
        cycle(1'b1, 1'b0, 1'($urandom));
        idle(3);
        shift_rand(37);
        idle(6);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0), 1'($urandom), 1'($urandom));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
